// File: rtl/bus_responder.sv
// Bus responder: 4 KiB RAM, GPIO, 8N1 UART transmitter and optional timer.
// Define BUS_RESPONDER_TIMER_EN to build the free-running timer at 0xFF04/0xFF05.
module bus_responder #(
  parameter int CLK_DIV = 16,
  parameter int RAM_AW  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic [15:0] address,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic [7:0]  gpio_in,
  output logic [7:0]  gpio_out,
  output logic        uart_tx
);

  localparam logic [15:0] A_GPIO_OUT    = 16'hFF00;
  localparam logic [15:0] A_GPIO_IN     = 16'hFF01;
  localparam logic [15:0] A_UART_DATA   = 16'hFF02;
  localparam logic [15:0] A_UART_STATUS = 16'hFF03;
`ifdef BUS_RESPONDER_TIMER_EN
  localparam logic [15:0] A_TIMER_L     = 16'hFF04;
  localparam logic [15:0] A_TIMER_H     = 16'hFF05;
`endif
  localparam int          RAM_WORDS     = 2 ** RAM_AW;
  localparam logic [16:0] RAM_END       = 17'(RAM_WORDS);
  localparam logic [15:0] BAUD_LAST     = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } uart_state_t;

  logic [7:0]  mem [RAM_WORDS];
  logic [7:0]  rdata_q;
  logic [7:0]  rdata_d;
  logic [7:0]  gpio_out_q;
  logic [7:0]  sync1_q;
  logic [7:0]  sync2_q;
  uart_state_t state_q;
  logic        tx_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic        busy;
  logic        ram_hit;
  logic        wr_en;
  logic        uart_wr;

  // Full 16-bit compare so nothing above the RAM aliases back into it.
  assign ram_hit = ({1'b0, address} < RAM_END);
  assign wr_en   = !rst && !read;
  assign uart_wr = wr_en && (address == A_UART_DATA);
  assign busy    = (state_q != S_IDLE);

  assign rdata    = rdata_q;
  assign gpio_out = gpio_out_q;
  assign uart_tx  = tx_q;

  // RAM has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en && ram_hit) begin
      mem[address[RAM_AW-1:0]] <= wdata;
    end
  end

`ifdef BUS_RESPONDER_TIMER_EN
  logic [15:0] timer_q;
  logic [7:0]  shadow_q;

  // TIMER_L read snapshots the high byte so a following TIMER_H read is coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= 16'h0000;
      shadow_q <= 8'h00;
    end else begin
      timer_q <= timer_q + 16'd1;
      if (read && (address == A_TIMER_L)) begin
        shadow_q <= timer_q[15:8];
      end
    end
  end
`endif

  always_comb begin
    rdata_d = 8'h00;
    if (ram_hit) begin
      rdata_d = mem[address[RAM_AW-1:0]];
    end else begin
      case (address)
        A_GPIO_OUT:    rdata_d = gpio_out_q;
        A_GPIO_IN:     rdata_d = sync2_q;
        A_UART_STATUS: rdata_d = {7'b0, busy};
`ifdef BUS_RESPONDER_TIMER_EN
        A_TIMER_L:     rdata_d = timer_q[7:0];
        A_TIMER_H:     rdata_d = shadow_q;
`endif
        default:       rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 8'h00;
    end else if (read) begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out_q <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      if (wr_en && (address == A_GPIO_OUT)) begin
        gpio_out_q <= wdata;
      end
    end
  end

  // UART TX: tx_q changes together with the state, so each bit lasts CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      baud_q    <= 16'd0;
      bit_idx_q <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (uart_wr) begin
            state_q <= S_START;
            tx_q    <= 1'b0;
            baud_q  <= 16'd0;
            shift_q <= wdata;
          end
        end
        S_START: begin
          if (baud_q == BAUD_LAST) begin
            baud_q    <= 16'd0;
            state_q   <= S_DATA;
            bit_idx_q <= 3'd0;
            tx_q      <= shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_q == BAUD_LAST) begin
            baud_q <= 16'd0;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= {1'b0, shift_q[7:1]};
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_STOP: begin
          if (baud_q == BAUD_LAST) begin
            baud_q  <= 16'd0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder (CLK_DIV=4): RAM, GPIO, UART, reset and timer/unmapped reads.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        read;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        uart_tx;

  int n_vec = 0;
  int n_err = 0;
  int since_rst = 0;

  bus_responder #(.CLK_DIV(4), .RAM_AW(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .read     (read),
    .address  (address),
    .wdata    (wdata),
    .rdata    (rdata),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .uart_tx  (uart_tx)
  );

  always #5 clk = ~clk;

  // Drive one bus cycle on negedge, return 1 time unit after the sampling posedge.
  task automatic drive(input logic rd, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    read    = rd;
    address = a;
    wdata   = d;
    @(posedge clk);
    #1;
    if (rst) since_rst = 0;
    else     since_rst++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Frame pattern bit i is the line level during bit period i (start, d0..d7, stop).
  task automatic run_frame(input logic [7:0] b, input logic [9:0] pat,
                           input bit inject, input logic [7:0] intruder);
    int i;
    drive(1'b0, 16'hFF02, b);
    chk("tx_k0", {7'b0, uart_tx}, {7'b0, pat[0]});
    for (int k = 1; k <= 40; k++) begin
      if (inject && k == 2) drive(1'b0, 16'hFF02, intruder);
      else                  drive(1'b1, 16'hFF03, 8'h00);
      i = k / 4;
      if (i > 9) i = 9;
      chk($sformatf("tx_k%0d", k), {7'b0, uart_tx}, {7'b0, pat[i]});
      chk($sformatf("busy_k%0d", k), rdata, 8'h01);
    end
    drive(1'b1, 16'hFF03, 8'h00);
    chk("busy_clear", rdata, 8'h00);
    chk("tx_idle", {7'b0, uart_tx}, 8'h01);
    repeat (6) drive(1'b1, 16'hFF03, 8'h00);
    chk("no_second_frame_status", rdata, 8'h00);
    chk("no_second_frame_tx", {7'b0, uart_tx}, 8'h01);
  endtask

  initial begin
    rst     = 1'b1;
    read    = 1'b1;
    address = 16'h0000;
    wdata   = 8'h00;
    gpio_in = 8'h00;

    // Reset state; writes during reset are ignored
    drive(1'b0, 16'hFF00, 8'hFF);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_gpio_out", gpio_out, 8'h00);
    chk("rst_tx", {7'b0, uart_tx}, 8'h01);
    drive(1'b0, 16'hFF02, 8'hAA);
    chk("rst_tx_after_uart_wr", {7'b0, uart_tx}, 8'h01);
    rst = 1'b0;
    drive(1'b1, 16'hFF03, 8'h00);
    chk("status_after_rst", rdata, 8'h00);

    // RAM write/read and decode boundaries
    drive(1'b0, 16'h0123, 8'hA5);
    chk("rdata_hold_on_write", rdata, 8'h00);
    drive(1'b1, 16'h0123, 8'h00);
    chk("ram_0123", rdata, 8'hA5);
    drive(1'b1, 16'h1123, 8'h00);
    chk("alias_1123_read", rdata, 8'h00);
    drive(1'b0, 16'h1123, 8'h77);
    drive(1'b1, 16'h0123, 8'h00);
    chk("alias_write_ignored", rdata, 8'hA5);
    drive(1'b0, 16'h0FFF, 8'h5A);
    drive(1'b0, 16'h0000, 8'hC3);
    drive(1'b1, 16'h0FFF, 8'h00);
    chk("ram_top", rdata, 8'h5A);
    drive(1'b1, 16'h0000, 8'h00);
    chk("ram_bottom", rdata, 8'hC3);
    drive(1'b1, 16'h1000, 8'h00);
    chk("ram_end_plus1", rdata, 8'h00);

    // GPIO
    drive(1'b0, 16'hFF00, 8'h3C);
    chk("gpio_out_wr", gpio_out, 8'h3C);
    drive(1'b1, 16'hFF00, 8'h00);
    chk("gpio_out_rd", rdata, 8'h3C);
    gpio_in = 8'h81;
    drive(1'b1, 16'hFF01, 8'h00);
    chk("gpio_in_lat1", rdata, 8'h00);
    drive(1'b1, 16'hFF01, 8'h00);
    chk("gpio_in_lat2", rdata, 8'h00);
    drive(1'b1, 16'hFF01, 8'h00);
    chk("gpio_in_lat3", rdata, 8'h81);

    // Unmapped and write-only reads
    drive(1'b1, 16'h8000, 8'h00);
    chk("unmapped_8000", rdata, 8'h00);
    drive(1'b1, 16'hFF02, 8'h00);
    chk("uart_data_wo", rdata, 8'h00);
    drive(1'b1, 16'hFF06, 8'h00);
    chk("unmapped_ff06", rdata, 8'h00);

    // UART frames: 0x55, then 0x11 with a dropped 0x22
    run_frame(8'h55, 10'b1010101010, 1'b0, 8'h00);
    run_frame(8'h11, 10'b1000100010, 1'b1, 8'h22);

    // Reset mid-frame
    drive(1'b0, 16'hFF02, 8'h00);
    chk("mid_tx_start", {7'b0, uart_tx}, 8'h00);
    repeat (5) drive(1'b1, 16'hFF03, 8'h00);
    chk("mid_busy", rdata, 8'h01);
    rst = 1'b1;
    drive(1'b1, 16'hFF03, 8'h00);
    rst = 1'b0;
    chk("mid_rst_tx", {7'b0, uart_tx}, 8'h01);
    chk("mid_rst_gpio", gpio_out, 8'h00);
    chk("mid_rst_rdata", rdata, 8'h00);
    drive(1'b1, 16'hFF04, 8'h00);
    chk("timer_l_after_rst", rdata, 8'h00);
    drive(1'b1, 16'hFF05, 8'h00);
    chk("timer_h_after_rst", rdata, 8'h00);
    drive(1'b1, 16'hFF03, 8'h00);
    chk("status_after_mid_rst", rdata, 8'h00);
    drive(1'b1, 16'h0123, 8'h00);
    chk("ram_kept_over_rst", rdata, 8'hA5);
    chk("tx_high_after_rst", {7'b0, uart_tx}, 8'h01);

`ifdef BUS_RESPONDER_TIMER_EN
    // Timer: a read at since_rst==m samples counter m-1
    while (since_rst < 32'h12FF) drive(1'b1, 16'h8000, 8'h00);
    drive(1'b1, 16'hFF04, 8'h00);
    chk("timer_l_12ff", rdata, 8'hFF);
    drive(1'b1, 16'hFF05, 8'h00);
    chk("timer_h_shadow", rdata, 8'h12);
    drive(1'b1, 16'hFF04, 8'h00);
    chk("timer_l_1301", rdata, 8'h01);
    drive(1'b1, 16'hFF05, 8'h00);
    chk("timer_h_13", rdata, 8'h13);
    while (since_rst < 32'hFFFF) drive(1'b1, 16'h8000, 8'h00);
    drive(1'b1, 16'hFF04, 8'h00);
    chk("timer_l_ffff", rdata, 8'hFF);
    drive(1'b1, 16'hFF05, 8'h00);
    chk("timer_h_ff", rdata, 8'hFF);
    drive(1'b1, 16'hFF04, 8'h00);
    chk("timer_l_wrap", rdata, 8'h01);
    drive(1'b1, 16'hFF05, 8'h00);
    chk("timer_h_wrap", rdata, 8'h00);
`else
    repeat (10) drive(1'b1, 16'h8000, 8'h00);
    drive(1'b1, 16'hFF04, 8'h00);
    chk("timer_l_absent", rdata, 8'h00);
    drive(1'b1, 16'hFF05, 8'h00);
    chk("timer_h_absent", rdata, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
